// File: rtl/sargantana_itag_lookup_ctrl_if.sv
// Bundle between the icache core / tag array side and the tag lookup controller.
// The slave modport is the controller; the master modport is everything around it.
interface sargantana_itag_lookup_ctrl_if #(
    parameter int unsigned ICACHE_N_WAY   = 4,
    parameter int unsigned TAG_DEPTH      = 64,
    parameter int unsigned TAG_ADDR_WIDHT = $clog2(TAG_DEPTH),
    parameter int unsigned TAG_WIDHT      = 20
);
    logic                              lookup_valid_i;
    logic                              lookup_ready_o;
    logic [TAG_ADDR_WIDHT-1:0]         lookup_idx_i;
    logic [TAG_WIDHT-1:0]              lookup_tag_i;

    logic                              resp_valid_o;
    logic                              resp_hit_o;
    logic [ICACHE_N_WAY-1:0]           resp_way_o;
    logic [ICACHE_N_WAY-1:0]           resp_victim_o;

    logic                              fill_valid_i;
    logic                              fill_ready_o;
    logic [TAG_ADDR_WIDHT-1:0]         fill_idx_i;
    logic [TAG_WIDHT-1:0]              fill_tag_i;
    logic [ICACHE_N_WAY-1:0]           fill_way_i;

    logic                              flush_req_i;

    logic [ICACHE_N_WAY-1:0]           tm_req_o;
    logic                              tm_we_o;
    logic                              tm_vbit_o;
    logic                              tm_flush_o;
    logic [TAG_WIDHT-1:0]              tm_data_o;
    logic [TAG_ADDR_WIDHT-1:0]         tm_addr_o;
    logic [ICACHE_N_WAY*TAG_WIDHT-1:0] tm_tag_way_i;
    logic [ICACHE_N_WAY-1:0]           tm_vbit_i;

    modport slave (
        input  lookup_valid_i, lookup_idx_i, lookup_tag_i,
        output lookup_ready_o,
        output resp_valid_o, resp_hit_o, resp_way_o, resp_victim_o,
        input  fill_valid_i, fill_idx_i, fill_tag_i, fill_way_i,
        output fill_ready_o,
        input  flush_req_i,
        output tm_req_o, tm_we_o, tm_vbit_o, tm_flush_o, tm_data_o, tm_addr_o,
        input  tm_tag_way_i, tm_vbit_i
    );

    modport master (
        output lookup_valid_i, lookup_idx_i, lookup_tag_i,
        input  lookup_ready_o,
        input  resp_valid_o, resp_hit_o, resp_way_o, resp_victim_o,
        output fill_valid_i, fill_idx_i, fill_tag_i, fill_way_i,
        input  fill_ready_o,
        output flush_req_i,
        input  tm_req_o, tm_we_o, tm_vbit_o, tm_flush_o, tm_data_o, tm_addr_o,
        output tm_tag_way_i, tm_vbit_i
    );
endinterface

// File: rtl/sargantana_itag_lookup_ctrl.sv
// Requester-side controller for the per-way icache tag array: lookup/compare,
// refill writes with round-robin victim tracking, and invalidate-all flush.
module sargantana_itag_lookup_ctrl #(
    parameter int unsigned ICACHE_N_WAY   = 4,
    parameter int unsigned TAG_DEPTH      = 64,
    parameter int unsigned TAG_ADDR_WIDHT = $clog2(TAG_DEPTH),
    parameter int unsigned TAG_WIDHT      = 20
) (
    input  logic                         clk_i,
    input  logic                         rstn_i,
    sargantana_itag_lookup_ctrl_if.slave bus
);
    localparam int unsigned NW = ICACHE_N_WAY;
    localparam int unsigned TW = TAG_WIDHT;
    localparam int unsigned AW = TAG_ADDR_WIDHT;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CMP   = 2'd1,
        FLUSH = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic            flush_pend_q, flush_pend_d;
    logic [NW-1:0]   rr_q, rr_d;
    logic [TW-1:0]   tag_q, tag_d;

    logic [NW-1:0]   way_match_c;
    logic [NW-1:0]   free_way_c;
    logic            any_free_c;

    logic            lookup_ready_c, fill_ready_c;
    logic            resp_valid_c, resp_hit_c;
    logic [NW-1:0]   resp_way_c, resp_victim_c;
    logic [NW-1:0]   tm_req_c;
    logic            tm_we_c, tm_vbit_c, tm_flush_c;
    logic [TW-1:0]   tm_data_c;
    logic [AW-1:0]   tm_addr_c;

    // Per-way compare against the tag captured at lookup accept.
    always_comb begin
        way_match_c = '0;
        for (int i = 0; i < int'(NW); i++) begin
            way_match_c[i] = bus.tm_vbit_i[i] && (bus.tm_tag_way_i[i*TW +: TW] == tag_q);
        end
    end

    // Lowest-index invalid way, preferred over the round-robin pointer.
    always_comb begin
        free_way_c = '0;
        any_free_c = 1'b0;
        for (int i = 0; i < int'(NW); i++) begin
            if (!any_free_c && !bus.tm_vbit_i[i]) begin
                free_way_c[i] = 1'b1;
                any_free_c    = 1'b1;
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        flush_pend_d   = flush_pend_q | bus.flush_req_i;
        rr_d           = rr_q;
        tag_d          = tag_q;
        lookup_ready_c = 1'b0;
        fill_ready_c   = 1'b0;
        resp_valid_c   = 1'b0;
        resp_hit_c     = 1'b0;
        resp_way_c     = '0;
        resp_victim_c  = '0;
        tm_req_c       = '0;
        tm_we_c        = 1'b0;
        tm_vbit_c      = 1'b0;
        tm_flush_c     = 1'b0;
        tm_data_c      = '0;
        tm_addr_c      = '0;

        unique case (state_q)
            IDLE: begin
                if (flush_pend_q) begin
                    // A flush request landing on this very cycle re-arms the pending flag.
                    state_d      = FLUSH;
                    flush_pend_d = bus.flush_req_i;
                end else begin
                    fill_ready_c   = rstn_i;
                    lookup_ready_c = rstn_i & ~bus.fill_valid_i;
                    if (bus.fill_valid_i && rstn_i) begin
                        if (|bus.fill_way_i) begin
                            tm_req_c  = bus.fill_way_i;
                            tm_we_c   = 1'b1;
                            tm_vbit_c = 1'b1;
                            tm_addr_c = bus.fill_idx_i;
                            tm_data_c = bus.fill_tag_i;
                            rr_d      = {rr_q[NW-2:0], rr_q[NW-1]};
                        end
                    end else if (bus.lookup_valid_i && rstn_i) begin
                        tm_req_c  = '1;
                        tm_addr_c = bus.lookup_idx_i;
                        tag_d     = bus.lookup_tag_i;
                        state_d   = CMP;
                    end
                end
            end
            CMP: begin
                resp_valid_c  = 1'b1;
                resp_way_c    = way_match_c;
                resp_hit_c    = |way_match_c;
                resp_victim_c = any_free_c ? free_way_c : rr_q;
                state_d       = IDLE;
            end
            FLUSH: begin
                tm_flush_c = 1'b1;
                rr_d       = NW'(1);
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q      <= IDLE;
            flush_pend_q <= 1'b0;
            rr_q         <= NW'(1);
            tag_q        <= '0;
        end else begin
            state_q      <= state_d;
            flush_pend_q <= flush_pend_d;
            rr_q         <= rr_d;
            tag_q        <= tag_d;
        end
    end

    assign bus.lookup_ready_o = lookup_ready_c;
    assign bus.fill_ready_o   = fill_ready_c;
    assign bus.resp_valid_o   = resp_valid_c;
    assign bus.resp_hit_o     = resp_hit_c;
    assign bus.resp_way_o     = resp_way_c;
    assign bus.resp_victim_o  = resp_victim_c;
    assign bus.tm_req_o       = tm_req_c;
    assign bus.tm_we_o        = tm_we_c;
    assign bus.tm_vbit_o      = tm_vbit_c;
    assign bus.tm_flush_o     = tm_flush_c;
    assign bus.tm_data_o      = tm_data_c;
    assign bus.tm_addr_o      = tm_addr_c;
endmodule

// File: tb/tb_sargantana_itag_lookup_ctrl.sv
// Directed bench for sargantana_itag_lookup_ctrl with a behavioural tag array
// that answers reads one cycle after the request.
module tb_sargantana_itag_lookup_ctrl;
    localparam int unsigned NW    = 4;
    localparam int unsigned DEPTH = 64;
    localparam int unsigned AW    = 6;
    localparam int unsigned TW    = 20;

    logic clk;
    logic rstn;

    sargantana_itag_lookup_ctrl_if #(
        .ICACHE_N_WAY(NW), .TAG_DEPTH(DEPTH), .TAG_ADDR_WIDHT(AW), .TAG_WIDHT(TW)
    ) bus ();

    sargantana_itag_lookup_ctrl #(
        .ICACHE_N_WAY(NW), .TAG_DEPTH(DEPTH), .TAG_ADDR_WIDHT(AW), .TAG_WIDHT(TW)
    ) dut (
        .clk_i  (clk),
        .rstn_i (rstn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Tag array model: write on we, registered read otherwise, flush/reset clear valids.
    logic [TW-1:0] mem_tag [NW][DEPTH];
    logic          mem_v   [NW][DEPTH];
    logic [TW-1:0] rd_tag  [NW];
    logic [NW-1:0] rd_v;
    logic [NW*TW-1:0] tag_bus_c;

    always @(posedge clk) begin
        if (!rstn || bus.tm_flush_o) begin
            for (int w = 0; w < int'(NW); w++)
                for (int s = 0; s < int'(DEPTH); s++)
                    mem_v[w][s] <= 1'b0;
        end else begin
            for (int w = 0; w < int'(NW); w++) begin
                if (bus.tm_req_o[w]) begin
                    if (bus.tm_we_o) begin
                        mem_tag[w][bus.tm_addr_o] <= bus.tm_data_o;
                        mem_v[w][bus.tm_addr_o]   <= bus.tm_vbit_o;
                    end else begin
                        rd_tag[w] <= mem_tag[w][bus.tm_addr_o];
                        rd_v[w]   <= mem_v[w][bus.tm_addr_o];
                    end
                end
            end
        end
    end

    always_comb begin
        tag_bus_c = '0;
        for (int w = 0; w < int'(NW); w++) tag_bus_c[w*TW +: TW] = rd_tag[w];
    end
    assign bus.tm_tag_way_i = tag_bus_c;
    assign bus.tm_vbit_i    = rd_v;

    int n_cmp;
    int n_bad;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef enum logic [1:0] {OP_FILL, OP_LOOK, OP_RST} op_e;
    typedef struct {
        op_e           op;
        logic [AW-1:0] idx;
        logic [TW-1:0] tag;
        logic [NW-1:0] way;       // fill way
        logic          exp_bit;   // fill: tm_we_o, lookup: resp_hit_o
        logic [NW-1:0] exp_vec;   // fill: tm_req_o, lookup: resp_way_o
        logic [NW-1:0] exp_vic;   // lookup: resp_victim_o
    } vec_t;

    localparam int NVEC = 16;
    vec_t vecs [NVEC];

    task automatic clear_inputs();
        bus.lookup_valid_i = 1'b0;
        bus.lookup_idx_i   = '0;
        bus.lookup_tag_i   = '0;
        bus.fill_valid_i   = 1'b0;
        bus.fill_idx_i     = '0;
        bus.fill_tag_i     = '0;
        bus.fill_way_i     = '0;
        bus.flush_req_i    = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        clear_inputs();
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic do_fill(input string nm, input logic [AW-1:0] idx, input logic [TW-1:0] tag,
                           input logic [NW-1:0] way, input logic exp_we, input logic [NW-1:0] exp_req);
        @(negedge clk);
        bus.fill_valid_i = 1'b1;
        bus.fill_idx_i   = idx;
        bus.fill_tag_i   = tag;
        bus.fill_way_i   = way;
        #1;
        check({nm, " fill_ready"}, 32'(bus.fill_ready_o), 32'd1);
        check({nm, " tm_we"},      32'(bus.tm_we_o),      32'(exp_we));
        check({nm, " tm_req"},     32'(bus.tm_req_o),     32'(exp_req));
        if (exp_we) begin
            check({nm, " tm_addr"}, 32'(bus.tm_addr_o), 32'(idx));
            check({nm, " tm_data"}, 32'(bus.tm_data_o), 32'(tag));
            check({nm, " tm_vbit"}, 32'(bus.tm_vbit_o), 32'd1);
        end
        @(negedge clk);
        bus.fill_valid_i = 1'b0;
    endtask

    task automatic do_look(input string nm, input logic [AW-1:0] idx, input logic [TW-1:0] tag,
                           input logic exp_hit, input logic [NW-1:0] exp_way, input logic [NW-1:0] exp_vic);
        @(negedge clk);
        bus.lookup_valid_i = 1'b1;
        bus.lookup_idx_i   = idx;
        bus.lookup_tag_i   = tag;
        #1;
        check({nm, " lookup_ready"}, 32'(bus.lookup_ready_o), 32'd1);
        check({nm, " rd tm_req"},    32'(bus.tm_req_o),       32'hF);
        check({nm, " rd tm_addr"},   32'(bus.tm_addr_o),      32'(idx));
        @(negedge clk);
        bus.lookup_valid_i = 1'b0;
        #1;
        check({nm, " resp_valid"},  32'(bus.resp_valid_o),  32'd1);
        check({nm, " resp_hit"},    32'(bus.resp_hit_o),    32'(exp_hit));
        check({nm, " resp_way"},    32'(bus.resp_way_o),    32'(exp_way));
        check({nm, " resp_victim"}, 32'(bus.resp_victim_o), 32'(exp_vic));
        check({nm, " cmp readies"}, 32'({bus.lookup_ready_o, bus.fill_ready_o}), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rstn  = 1'b0;
        clear_inputs();

        vecs[0]  = '{OP_FILL, 6'd5, 20'hABCDE, 4'b0010, 1'b1, 4'b0010, 4'b0000};
        vecs[1]  = '{OP_LOOK, 6'd5, 20'hABCDE, 4'b0000, 1'b1, 4'b0010, 4'b0001};
        vecs[2]  = '{OP_LOOK, 6'd3, 20'h12345, 4'b0000, 1'b0, 4'b0000, 4'b0001};
        vecs[3]  = '{OP_RST,  6'd0, 20'h00000, 4'b0000, 1'b0, 4'b0000, 4'b0000};
        vecs[4]  = '{OP_FILL, 6'd7, 20'h11111, 4'b0001, 1'b1, 4'b0001, 4'b0000};
        vecs[5]  = '{OP_FILL, 6'd7, 20'h22222, 4'b0010, 1'b1, 4'b0010, 4'b0000};
        vecs[6]  = '{OP_FILL, 6'd7, 20'h33333, 4'b0100, 1'b1, 4'b0100, 4'b0000};
        vecs[7]  = '{OP_FILL, 6'd7, 20'h44444, 4'b1000, 1'b1, 4'b1000, 4'b0000};
        vecs[8]  = '{OP_LOOK, 6'd7, 20'h99999, 4'b0000, 1'b0, 4'b0000, 4'b0001};
        vecs[9]  = '{OP_FILL, 6'd7, 20'h11111, 4'b0001, 1'b1, 4'b0001, 4'b0000};
        vecs[10] = '{OP_LOOK, 6'd7, 20'h99999, 4'b0000, 1'b0, 4'b0000, 4'b0010};
        vecs[11] = '{OP_LOOK, 6'd7, 20'h33333, 4'b0000, 1'b1, 4'b0100, 4'b0010};
        vecs[12] = '{OP_FILL, 6'd7, 20'h99999, 4'b0000, 1'b0, 4'b0000, 4'b0000};
        vecs[13] = '{OP_LOOK, 6'd7, 20'h99999, 4'b0000, 1'b0, 4'b0000, 4'b0010};
        vecs[14] = '{OP_FILL, 6'd9, 20'h55555, 4'b0101, 1'b1, 4'b0101, 4'b0000};
        vecs[15] = '{OP_LOOK, 6'd9, 20'h55555, 4'b0000, 1'b1, 4'b0101, 4'b0010};

        // Reset state.
        repeat (2) @(negedge clk);
        #1;
        check("rst readies",    32'({bus.lookup_ready_o, bus.fill_ready_o}), 32'd0);
        check("rst resp_valid", 32'(bus.resp_valid_o), 32'd0);
        check("rst tm_req",     32'(bus.tm_req_o),     32'd0);
        check("rst tm_flush",   32'(bus.tm_flush_o),   32'd0);
        @(negedge clk);
        rstn = 1'b1;
        #1;
        check("post-rst readies", 32'({bus.lookup_ready_o, bus.fill_ready_o}), 32'd3);
        check("idle tm_addr",     32'(bus.tm_addr_o), 32'd0);

        for (int k = 0; k < NVEC; k++) begin
            case (vecs[k].op)
                OP_FILL: do_fill($sformatf("v%0d", k), vecs[k].idx, vecs[k].tag, vecs[k].way,
                                 vecs[k].exp_bit, vecs[k].exp_vec);
                OP_LOOK: do_look($sformatf("v%0d", k), vecs[k].idx, vecs[k].tag,
                                 vecs[k].exp_bit, vecs[k].exp_vec, vecs[k].exp_vic);
                default: do_reset();
            endcase
        end

        // Flush pulsed during CMP: response intact, one stalled IDLE, one FLUSH cycle.
        do_fill("fl", 6'd5, 20'hABCDE, 4'b0010, 1'b1, 4'b0010);
        @(negedge clk);
        bus.lookup_valid_i = 1'b1;
        bus.lookup_idx_i   = 6'd5;
        bus.lookup_tag_i   = 20'hABCDE;
        @(negedge clk);
        bus.lookup_valid_i = 1'b0;
        bus.flush_req_i    = 1'b1;
        #1;
        check("fl resp_valid", 32'(bus.resp_valid_o), 32'd1);
        check("fl resp_hit",   32'(bus.resp_hit_o),   32'd1);
        check("fl resp_way",   32'(bus.resp_way_o),   32'b0010);
        @(negedge clk);
        bus.flush_req_i = 1'b0;
        #1;
        check("fl pend readies", 32'({bus.lookup_ready_o, bus.fill_ready_o}), 32'd0);
        check("fl pend tm_flush", 32'(bus.tm_flush_o), 32'd0);
        @(negedge clk);
        #1;
        check("fl tm_flush", 32'(bus.tm_flush_o), 32'd1);
        check("fl tm_req",   32'(bus.tm_req_o),   32'd0);
        check("fl tm_we",    32'(bus.tm_we_o),    32'd0);
        @(negedge clk);
        #1;
        check("fl after tm_flush", 32'(bus.tm_flush_o), 32'd0);
        check("fl after readies",  32'({bus.lookup_ready_o, bus.fill_ready_o}), 32'd3);
        do_look("fl relook", 6'd5, 20'hABCDE, 1'b0, 4'b0000, 4'b0001);

        // Fill and lookup together: fill wins, lookup accepted next cycle.
        @(negedge clk);
        bus.fill_valid_i   = 1'b1;
        bus.fill_idx_i     = 6'd2;
        bus.fill_tag_i     = 20'h0F0F0;
        bus.fill_way_i     = 4'b1000;
        bus.lookup_valid_i = 1'b1;
        bus.lookup_idx_i   = 6'd2;
        bus.lookup_tag_i   = 20'h0F0F0;
        #1;
        check("co fill_ready",   32'(bus.fill_ready_o),   32'd1);
        check("co lookup_ready", 32'(bus.lookup_ready_o), 32'd0);
        check("co tm_we",        32'(bus.tm_we_o),        32'd1);
        check("co tm_req",       32'(bus.tm_req_o),       32'b1000);
        @(negedge clk);
        bus.fill_valid_i = 1'b0;
        #1;
        check("co lookup_ready2", 32'(bus.lookup_ready_o), 32'd1);
        check("co rd tm_req",     32'(bus.tm_req_o),       32'hF);
        @(negedge clk);
        bus.lookup_valid_i = 1'b0;
        #1;
        check("co resp_hit",    32'(bus.resp_hit_o),    32'd1);
        check("co resp_way",    32'(bus.resp_way_o),    32'b1000);
        check("co resp_victim", 32'(bus.resp_victim_o), 32'b0001);

        // Reset asserted mid-CMP drops the response.
        @(negedge clk);
        bus.lookup_valid_i = 1'b1;
        @(negedge clk);
        bus.lookup_valid_i = 1'b0;
        #1;
        check("rc resp_valid", 32'(bus.resp_valid_o), 32'd1);
        rstn = 1'b0;
        #1;
        check("rc drop resp_valid", 32'(bus.resp_valid_o), 32'd0);
        check("rc drop resp_hit",   32'(bus.resp_hit_o),   32'd0);
        check("rc rst readies",     32'({bus.lookup_ready_o, bus.fill_ready_o}), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        #1;
        check("rc release readies", 32'({bus.lookup_ready_o, bus.fill_ready_o}), 32'd3);
        check("rc release resp",    32'(bus.resp_valid_o), 32'd0);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/sargantana_itag_lookup_ctrl.md
Name: sargantana_itag_lookup_ctrl

Overview:
Controller that sits on the requester side of the per-way instruction tag memory. It performs index reads and same-way tag/valid comparison to produce hit and way responses. It writes refilled tags with the valid bit set, selects victim ways and sequences the flush. It sits between the icache core FSM (lookup and fill requests) and the tag memory array.

Parameters:
ICACHE_N_WAY, 4, number of ways. Legal range is 2..8.
TAG_DEPTH, 64, number of sets.
TAG_ADDR_WIDHT, $clog2(TAG_DEPTH), width of the set index.
TAG_WIDHT, 20, width of a stored tag.

Ports:
clk_i  in  1  clock
rstn_i  in  1  reset. Asynchronous, active-low.
lookup_valid_i  in  1  lookup request
lookup_ready_o  out  1  lookup accepted when valid and ready are both high
lookup_idx_i  in  TAG_ADDR_WIDHT  set index
lookup_tag_i  in  TAG_WIDHT  tag to compare
resp_valid_o  out  1  one-cycle response strobe. Not back-pressurable.
resp_hit_o  out  1  at least one way matched
resp_way_o  out  ICACHE_N_WAY  per-way match vector
resp_victim_o  out  ICACHE_N_WAY  one-hot victim proposal for a refill
fill_valid_i  in  1  tag write request
fill_ready_o  out  1  fill accepted when valid and ready are both high
fill_idx_i  in  TAG_ADDR_WIDHT  fill set index
fill_tag_i  in  TAG_WIDHT  fill tag
fill_way_i  in  ICACHE_N_WAY  one-hot way to write
flush_req_i  in  1  invalidate-all pulse
tm_req_o  out  ICACHE_N_WAY  per-way tag memory request
tm_we_o  out  1  tag memory write enable
tm_vbit_o  out  1  valid bit to write
tm_flush_o  out  1  tag memory flush
tm_data_o  out  TAG_WIDHT  tag to write
tm_addr_o  out  TAG_ADDR_WIDHT  tag memory index
tm_tag_way_i  in  ICACHE_N_WAY*TAG_WIDHT  read tags. Way i occupies bits [i*TAG_WIDHT +: TAG_WIDHT].
tm_vbit_i  in  ICACHE_N_WAY  read valid bits

Behaviour:
- Tag memory has synchronous read. tag/vbit for a request at cycle N are valid at cycle N+1.
- FSM states: IDLE, CMP, FLUSH.
- flush_pend register: set by flush_req_i in any state; cleared on entry to FLUSH.
- IDLE, priority flush_pend > fill > lookup:
  - If flush_pend is set: go to FLUSH. Both ready outputs are low.
  - Otherwise fill_ready_o = 1. lookup_ready_o = !fill_valid_i.
  - Fill accept, same cycle (combinational): tm_req_o = fill_way_i, tm_we_o = 1, tm_vbit_o = 1, tm_addr_o = fill_idx_i, tm_data_o = fill_tag_i. State stays IDLE. The round-robin pointer rotates left by 1 (with wrap).
  - Lookup accept, same cycle: tm_req_o = all ones, tm_we_o = 0, tm_addr_o = lookup_idx_i. Register the tag. Go to CMP.
- CMP, one cycle:
  - resp_valid_o = 1.
  - resp_way_o[i] = tm_vbit_i[i] & (way i tag == registered tag).
  - resp_hit_o = |resp_way_o.
  - resp_victim_o = lowest-index way with tm_vbit_i == 0. If all ways are valid, it is the round-robin pointer.
  - Both ready outputs are low. Next state is IDLE.
  - A flush arriving in this cycle does not affect the response. The flush executes after the return to IDLE.
- FLUSH, one cycle: tm_flush_o = 1, tm_req_o = 0, tm_we_o = 0. Round-robin pointer resets to way 0. Next state is IDLE.
- Lookup throughput is 1 per 2 cycles. Lookup-to-response latency is 1 cycle.
- Memory outputs when no request or flush is active: tm_req_o = 0, tm_we_o = 0, tm_flush_o = 0, tm_vbit_o = 0, tm_data_o = 0, tm_addr_o = 0.
- fill_way_i values:
  - 0: the fill is accepted with no write and no pointer update.
  - Multiple bits set: every selected way is written. The pointer still rotates.
- Multiple tag matches report all matching bits. This is not an error.
- Reset:
  - State IDLE, flush_pend = 0, pointer = way 0 one-hot, registered tag = 0.
  - resp_valid_o, resp_hit_o, resp_way_o, resp_victim_o, tm_* outputs all 0.
  - Both ready outputs are 0 while rstn_i is low, and 1 in the first cycle after release.
  - Reset asserted mid-CMP drops the response.

Test Plan:
- Fill idx 5, tag 0xABCDE, way 0010. Then lookup idx 5, tag 0xABCDE. Expect tm_we_o = 1 and tm_req_o = 0010 on the fill cycle. Expect resp_valid_o = 1 one cycle after lookup accept, resp_hit_o = 1, resp_way_o = 0010.
- After reset, lookup idx 3, tag 0x12345 -> resp_hit_o = 0, resp_way_o = 0000, resp_victim_o = 0001.
- Fill all 4 ways of idx 7 with distinct tags, then lookup a miss. Expect resp_victim_o equal to the round-robin pointer, which is 0001 after 4 rotations from reset. Repeat with one more fill and expect 0010.
- Pulse flush_req_i during CMP. Expect the response unaffected, then one IDLE cycle with both readies low, then tm_flush_o = 1 for exactly 1 cycle. A subsequent lookup of a previously hit tag gives resp_hit_o = 0.
- Assert fill_valid_i and lookup_valid_i together in IDLE -> fill accepted, lookup_ready_o = 0. The lookup is accepted in the next cycle.
- Assert rstn_i low during CMP -> resp_valid_o drops to 0 immediately. State is IDLE with both readies high after release.
